jtag_dma_engine: RTL
====================

// Module: jtag_dma_engine
// PURPOSE
//  System-clock DMA engine behind the JTAG chain-1 controller. Consumes launch pulses (write/read/switch)
//  plus address, byte-enable, burst and block-size settings; moves words between its half of the
//  ping-pong buffer and the system bus in bursts. Reports busy/done/valid-word-count back to chain 1.
// PARAMETERS
//  MAX_BURST  16  maximum beats per bus transaction (power of 2, <=256)
// PORTS
//  clock               in   1   system clock; only clock of the block
//  reset               in   1   synchronous, active-high reset
//  launch_write        in   1   1-cycle pulse: buffer -> bus, block_size words
//  launch_read         in   1   1-cycle pulse: bus -> buffer, block_size words
//  launch_switch       in   1   1-cycle pulse: buffer halves swapped, no transfer
//  address             in   32  start byte address (word aligned, bits[1:0] ignored)
//  byte_enable         in   4   byte enables for every beat
//  burst_size          in   8   requested beats-1 per burst
//  block_size          in   8   word count to transfer
//  busy                out  1   operation in progress
//  operation_done      out  1   sticky: last operation finished
//  error               out  1   sticky: last operation aborted by bus error
//  block_size_out      out  8   valid words in DMA buffer half
//  buf_address         out  9   DMA-side buffer address, bit8 always 0
//  buf_write_enable    out  1   buffer write strobe
//  buf_data_in         out  32  buffer write data
//  buf_data_out        in   32  buffer read data, 1-cycle latency
//  bus_request / bus_grant         out/in 1  arbitration
//  begin_transaction_out           out  1   1-cycle transaction start
//  address_data_out                out  32  address on begin, data on write beats
//  byte_enables_out / burst_size_out / read_n_write_out  out 4/8/1  valid with begin only, else 0
//  data_valid_out / end_transaction_out   out 1  write beat strobe / master end of write burst
//  address_data_in / data_valid_in / end_transaction_in / busy_in / error_in  in 32/1/1/1/1  slave side
// BEHAVIOUR
//  Reset: all outputs 0; block_size_out=0; state IDLE.
//  Launch accepted only in IDLE; pulses while busy ignored. Simultaneous pulses: priority switch>write>read.
//  Accept: latch address/byte_enable/block_size, beats=min(burst_size+1,MAX_BURST); clear done/error;
//   busy=1 next cycle. launch_write/launch_switch also clear block_size_out; launch_read clears it too.
//  launch_switch or block_size==0: go DONE directly (busy 1 cycle, then done=1), no bus activity.
//  States: IDLE -> REQ (bus_request=1 until grant) -> BEGIN (1 cycle, begin_transaction_out) ->
//   WDATA | RDATA -> NEXT -> REQ or DONE; ERROR on error_in in any bus state; DONE/ERROR -> IDLE.
//  Burst length n=min(beats, remaining); burst_size_out=n-1; address advances 4*n bytes per burst,
//   wraps modulo 2^32; word index advances n (8-bit).
//  WDATA: buffer prefetched one cycle ahead (buf_address=word index); data_valid_out=1 per beat,
//   beat and prefetch held while busy_in=1; after n beats end_transaction_out=1 for 1 cycle.
//  RDATA: each data_valid_in writes address_data_in to buf_address=index, buf_write_enable=1,
//   block_size_out+1; end_transaction_in ends burst (short bursts tolerated, remaining adjusted).
//  ERROR: bus_request dropped, end_transaction_out 1 cycle if master-owned, error=1, done=1, busy=0.
//  DONE: busy=0, operation_done=1 held until next accepted launch. block_size_out keeps word count.
//  reset mid-operation: immediate return to IDLE, bus outputs 0 in the same edge.
// STRUCTURE
//  Package jtag_dma_pkg: state encoding, MAX_BURST default, launch opcode priority constants.
//  Single module; no sub-module warranted (prefetch register and counters inline).
// TESTING
//  read N=5, burst_size=3, addr 0x100: two bursts (4@0x100, 1@0x110), buf idx 0..4, block_size_out=5, done=1.
//  write N=3, busy_in high 2 cycles on beat 2: beat held, data = buf[0..2] in order, end_transaction once.
//  launch_switch: busy 1 cycle, no bus_request, block_size_out=0, done=1.
//  block_size=0 write: no bus activity, done=1, error=0.
//  error_in on beat 2 of read N=8: error=1, done=1, block_size_out=1, IDLE next cycle.
//  launch_read pulse while busy: ignored, current transfer completes unchanged.

Source files
------------

// File: rtl/jtag_dma_pkg.sv
// jtag_dma_pkg: state encoding, burst limit default and launch priority decode for the chain-1 DMA engine
package jtag_dma_pkg;
   localparam int MAX_BURST_DEF = 16;
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_BEGIN, S_WDATA, S_RDATA, S_NEXT, S_DONE, S_ERROR} state_e;
   typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_SWITCH} op_e;
   function automatic op_e decode_launch(input logic sw, input logic wr, input logic rd);
      return sw ? OP_SWITCH : wr ? OP_WRITE : rd ? OP_READ : OP_NONE;
   endfunction
endpackage

// File: rtl/jtag_dma_engine.sv
// jtag_dma_engine: moves block_size words between the DMA buffer half and the system bus in bursts
module jtag_dma_engine
   import jtag_dma_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        launch_write_i,
   input  logic        launch_read_i,
   input  logic        launch_switch_i,
   input  logic [31:0] address_i,
   input  logic [3:0]  byte_enable_i,
   input  logic [7:0]  burst_size_i,
   input  logic [7:0]  block_size_i,
   output logic        busy_o,
   output logic        operation_done_o,
   output logic        error_o,
   output logic [7:0]  block_size_out_o,
   output logic [8:0]  buf_address_o,
   output logic        buf_write_enable_o,
   output logic [31:0] buf_data_in_o,
   input  logic [31:0] buf_data_out_i,
   output logic        bus_request_o,
   input  logic        bus_grant_i,
   output logic        begin_transaction_out_o,
   output logic [31:0] address_data_out_o,
   output logic [3:0]  byte_enables_out_o,
   output logic [7:0]  burst_size_out_o,
   output logic        read_n_write_out_o,
   output logic        data_valid_out_o,
   output logic        end_transaction_out_o,
   input  logic [31:0] address_data_in_i,
   input  logic        data_valid_in_i,
   input  logic        end_transaction_in_i,
   input  logic        busy_in_i,
   input  logic        error_in_i
);
   state_e      state_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [8:0]  beats_q;
   logic [7:0]  rem_q, idx_q, bidx_q, n_q, cnt_q;
   logic        write_q;
   op_e         op_d;
   logic [8:0]  req_beats, beats_d;
   logic [7:0]  n_d;
   logic        accept, abort, last_beat;
   assign op_d      = decode_launch(launch_switch_i, launch_write_i, launch_read_i);
   assign req_beats = {1'b0, burst_size_i} + 9'd1;
   assign beats_d   = (req_beats > 9'(MAX_BURST)) ? 9'(MAX_BURST) : req_beats;
   assign n_d       = (beats_q < {1'b0, rem_q}) ? beats_q[7:0] : rem_q;
   assign accept    = (state_q == S_WDATA) && !busy_in_i;
   assign abort     = error_in_i && (state_q inside {S_REQ, S_BEGIN, S_WDATA, S_RDATA, S_NEXT});
   assign last_beat = cnt_q == n_q - 8'd1;
   // bidx_q points at the word after the one on the bus; an accepted beat fetches one further so the
   // 1-cycle buffer latency still delivers the next word exactly when it is needed
   assign buf_address_o = {1'b0, accept ? bidx_q + 8'd1 : bidx_q};
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q                 <= S_IDLE;
         addr_q                  <= '0;
         be_q                    <= '0;
         beats_q                 <= '0;
         rem_q                   <= '0;
         idx_q                   <= '0;
         bidx_q                  <= '0;
         n_q                     <= '0;
         cnt_q                   <= '0;
         write_q                 <= 1'b0;
         busy_o                  <= 1'b0;
         operation_done_o        <= 1'b0;
         error_o                 <= 1'b0;
         block_size_out_o        <= '0;
         buf_write_enable_o      <= 1'b0;
         buf_data_in_o           <= '0;
         bus_request_o           <= 1'b0;
         begin_transaction_out_o <= 1'b0;
         address_data_out_o      <= '0;
         byte_enables_out_o      <= '0;
         burst_size_out_o        <= '0;
         read_n_write_out_o      <= 1'b0;
         data_valid_out_o        <= 1'b0;
         end_transaction_out_o   <= 1'b0;
      end else begin
         begin_transaction_out_o <= 1'b0;
         byte_enables_out_o      <= '0;
         burst_size_out_o        <= '0;
         read_n_write_out_o      <= 1'b0;
         address_data_out_o      <= '0;
         data_valid_out_o        <= 1'b0;
         end_transaction_out_o   <= 1'b0;
         buf_write_enable_o      <= 1'b0;
         if (abort) begin
            state_q               <= S_ERROR;
            bus_request_o         <= 1'b0;
            end_transaction_out_o <= state_q == S_WDATA;
         end else begin
            case (state_q)
               S_IDLE: if (op_d != OP_NONE) begin
                  addr_q           <= address_i & ~32'd3;
                  be_q             <= byte_enable_i;
                  beats_q          <= beats_d;
                  rem_q            <= block_size_i;
                  idx_q            <= '0;
                  bidx_q           <= '0;
                  write_q          <= op_d == OP_WRITE;
                  operation_done_o <= 1'b0;
                  error_o          <= 1'b0;
                  busy_o           <= 1'b1;
                  block_size_out_o <= '0;
                  state_q          <= (op_d == OP_SWITCH || block_size_i == 8'd0) ? S_DONE : S_REQ;
                  bus_request_o    <= !(op_d == OP_SWITCH || block_size_i == 8'd0);
               end
               S_REQ: if (bus_grant_i) begin
                  state_q                 <= S_BEGIN;
                  begin_transaction_out_o <= 1'b1;
                  address_data_out_o      <= addr_q;
                  byte_enables_out_o      <= be_q;
                  burst_size_out_o        <= n_d - 8'd1;
                  read_n_write_out_o      <= !write_q;
                  n_q                     <= n_d;
                  cnt_q                   <= '0;
                  bidx_q                  <= idx_q + 8'd1;
               end
               S_BEGIN: begin
                  state_q            <= write_q ? S_WDATA : S_RDATA;
                  data_valid_out_o   <= write_q;
                  address_data_out_o <= write_q ? buf_data_out_i : 32'd0;
               end
               S_WDATA: if (busy_in_i) begin
                  data_valid_out_o   <= 1'b1;
                  address_data_out_o <= address_data_out_o;
               end else begin
                  idx_q                 <= idx_q + 8'd1;
                  bidx_q                <= bidx_q + 8'd1;
                  rem_q                 <= rem_q - 8'd1;
                  addr_q                <= addr_q + 32'd4;
                  cnt_q                 <= cnt_q + 8'd1;
                  end_transaction_out_o <= last_beat;
                  data_valid_out_o      <= !last_beat;
                  address_data_out_o    <= last_beat ? 32'd0 : buf_data_out_i;
                  state_q               <= last_beat ? S_NEXT : S_WDATA;
               end
               S_RDATA: begin
                  if (data_valid_in_i && rem_q != 8'd0) begin
                     buf_write_enable_o <= 1'b1;
                     buf_data_in_o      <= address_data_in_i;
                     bidx_q             <= idx_q;
                     idx_q              <= idx_q + 8'd1;
                     rem_q              <= rem_q - 8'd1;
                     addr_q             <= addr_q + 32'd4;
                     block_size_out_o   <= block_size_out_o + 8'd1;
                  end
                  if (end_transaction_in_i) state_q <= S_NEXT;
               end
               S_NEXT: begin
                  bus_request_o <= rem_q != 8'd0;
                  bidx_q        <= idx_q;
                  state_q       <= rem_q != 8'd0 ? S_REQ : S_DONE;
               end
               S_DONE: begin
                  busy_o           <= 1'b0;
                  operation_done_o <= 1'b1;
                  bus_request_o    <= 1'b0;
                  state_q          <= S_IDLE;
               end
               S_ERROR: begin
                  busy_o           <= 1'b0;
                  operation_done_o <= 1'b1;
                  error_o          <= 1'b1;
                  state_q          <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule
